mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares the processor's single-port 16-bit memory between the instruction-fetch path and the data path (LD, ST, CALL/RET stack traffic). It sits between the control unit's memory requests and the memory macro. It serialises accesses, counts the memory's fixed read latency, and returns read data with a valid pulse. An anti-starvation rule keeps fetch from being locked out by back-to-back data accesses.

---
 rtl/proc16_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/arb_starve_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc16_pkg.sv
// rtl/proc16_pkg.sv - shared FSM encodings, owner IDs and defaults for the memory port arbiter
package proc16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  // MEM_LAT is at most 7 and STARVE_MAX at most 15
  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-macro buses of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // arbiter side
  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requesters and memory macro side
  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb_starve_pick.sv
// rtl/arb_starve_pick.sv - data-first winner selection with a fetch anti-starvation counter
module arb_starve_pick
  import proc16_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic any_req,
  output logic fetch_win
);

  logic [STARVE_W-1:0] starve_cnt;

  assign any_req   = if_req | d_req;
  assign fetch_win = if_req & (~d_req | (starve_cnt == STARVE_W'(STARVE_MAX)));

  // counts data wins taken while fetch was waiting; fetch wins before it can wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (arb_en && any_req) begin
      if (fetch_win || !if_req) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and data accesses onto one single-port memory
module mem_port_arbiter
  import proc16_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic               owner
);

  arb_state_t        state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              any_req;
  logic              fetch_win;

  logic              if_gnt_q;
  logic              d_gnt_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     if_rdata_q;
  logic [DW-1:0]     d_rdata_q;

  arb_starve_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (state == ST_IDLE),
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .any_req   (any_req),
    .fetch_win (fetch_win)
  );

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // the memory strobes are loaded on the IDLE->ISSUE edge so they appear during ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      busy        <= 1'b0;
      owner       <= OWN_IF;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_ISSUE;
            busy     <= 1'b1;
            mem_en_q <= 1'b1;
            if (fetch_win) begin
              owner    <= OWN_IF;
              if_gnt_q <= 1'b1;
              addr_q   <= bus.if_addr;
            end else begin
              owner    <= OWN_D;
              d_gnt_q  <= 1'b1;
              addr_q   <= bus.d_addr;
              mem_we_q <= bus.d_we;
              wdata_q  <= bus.d_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_we_q) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            lat_cnt <= LAT_W'(MEM_LAT - 1);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ST_DONE;
            if (owner == OWN_IF) begin
              if_rdata_q  <= bus.mem_rdata;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= bus.mem_rdata;
              d_rvalid_q <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, owner, busy3, owner3;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  int          gq[$];
  int          exp_order [6] = '{1, 1, 1, 1, 0, 1};
  bit          drop_if;
  bit          ok, seen_g, seen_v;
  logic [15:0] rd;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) bus3 ();

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3), .owner(owner3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0004) ? 16'h8C40 : {a[7:0], ~a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic go_neg(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  // memory macros: writes land on the strobe edge, reads appear LAT cycles after the strobe cycle
  logic [15:0] mem1 [0:255];
  logic [15:0] pipe1 [0:7];
  bit          ready1 = 1'b0;
  always @(posedge clk) begin
    if (!ready1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_val(16'(i));
      ready1 <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      mem1[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    pipe1[0] <= (bus.mem_en && !bus.mem_we) ? mem1[bus.mem_addr[7:0]] : 16'hDEAD;
    for (int i = 1; i < 8; i++) pipe1[i] <= pipe1[i-1];
  end
  assign bus.mem_rdata = pipe1[LAT1-1];

  logic [15:0] mem3 [0:255];
  logic [15:0] pipe3 [0:7];
  bit          ready3 = 1'b0;
  always @(posedge clk) begin
    if (!ready3) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_val(16'(i));
      ready3 <= 1'b1;
    end else if (bus3.mem_en && bus3.mem_we) begin
      mem3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
    end
    pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr[7:0]] : 16'hDEAD;
    for (int i = 1; i < 8; i++) pipe3[i] <= pipe3[i-1];
  end
  assign bus3.mem_rdata = pipe3[LAT3-1];

  // transaction-schedule model of the main instance, checked every cycle
  initial begin : model
    logic [15:0] ref_mem [0:255];
    bit          act, tf, twe, rv, fw, e_mem_en;
    int          s, tend, starve, c;
    logic [15:0] ta, tw, tdata, e_if_rd, e_d_rd;
    logic        e_owner;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(16'(i));
    act = 0; tf = 0; twe = 0; s = 0; tend = 0; starve = 0;
    ta = '0; tw = '0; tdata = '0; e_if_rd = '0; e_d_rd = '0; e_owner = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 0; e_if_rd = '0; e_d_rd = '0; e_owner = 1'b0; starve = 0;
        chk("rst_if_gnt", 32'(bus.if_gnt), 0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
        chk("rst_if_rdata", 32'(bus.if_rdata), 0);
        chk("rst_d_rdata", 32'(bus.d_rdata), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_starve", 32'(dut.u_pick.starve_cnt), 0);
      end else begin
        c = cyc;
        if (act && c >= tend) act = 0;
        e_mem_en = act && (c == s + 1);
        if (e_mem_en) e_owner = !tf;
        rv = act && !twe && (c == s + 2 + LAT1);
        if (rv && tf) e_if_rd = tdata;
        if (rv && !tf) e_d_rd = tdata;
        chk("if_gnt", 32'(bus.if_gnt), 32'(e_mem_en && tf));
        chk("d_gnt", 32'(bus.d_gnt), 32'(e_mem_en && !tf));
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(rv && tf));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(rv && !tf));
        chk("if_rdata", 32'(bus.if_rdata), 32'(e_if_rd));
        chk("d_rdata", 32'(bus.d_rdata), 32'(e_d_rd));
        chk("mem_en", 32'(bus.mem_en), 32'(e_mem_en));
        chk("busy", 32'(busy), 32'(act && c > s));
        chk("owner", 32'(owner), 32'(e_owner));
        chk("starve_cnt", 32'(dut.u_pick.starve_cnt), 32'(starve));
        if (e_mem_en) begin
          chk("mem_we", 32'(bus.mem_we), 32'(twe));
          chk("mem_addr", 32'(bus.mem_addr), 32'(ta));
          if (twe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(tw));
        end
        if (!act && (bus.if_req || bus.d_req)) begin
          // fetch only beats a waiting data request after SMAX straight data wins
          fw = bus.if_req && (!bus.d_req || starve == SMAX);
          starve = (fw || !bus.if_req) ? 0 : starve + 1;
          tf   = fw;
          twe  = !fw && bus.d_we;
          ta   = fw ? bus.if_addr : bus.d_addr;
          tw   = bus.d_wdata;
          s    = c;
          act  = 1;
          tend = twe ? s + 2 : s + 3 + LAT1;
          if (twe) ref_mem[ta[7:0]] = tw;
          tdata = ref_mem[ta[7:0]];
        end
      end
    end
  end

  task automatic data_read(input logic [15:0] a, output logic [15:0] d, output bit done);
    bit g;
    g = 0; done = 0; d = '0;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.d_gnt) g = 1;
      if (bus.d_rvalid) begin
        done = 1;
        d = bus.d_rdata;
      end
      @(posedge clk); #1;
      if (g) bus.d_req = 1'b0;
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus3.if_req = 0; bus3.if_addr = '0; bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = '0; bus3.d_wdata = '0;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_busy3", 32'(busy3), 0);
    chk("reset_mem_en3", 32'(bus3.mem_en), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // MEM_LAT=3 data read: rvalid five cycles after sampling, strobe only in ISSUE
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 16'h0020;
    go_neg(1);
    chk("t4_gnt", 32'(bus3.d_gnt), 1);
    chk("t4_mem_en1", 32'(bus3.mem_en), 1);
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) bus3.d_req = 1'b0;
      @(negedge clk);
      chk("t4_mem_en", 32'(bus3.mem_en), 0);
      chk("t4_rvalid", 32'(bus3.d_rvalid), 32'(k == 5));
      chk("t4_busy", 32'(busy3), 32'(k <= 5));
      if (k == 5) chk("t4_rdata", 32'(bus3.d_rdata), 32'h20DF);
    end

    // data write
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'hBEEF;
    go_neg(1);
    chk("t1_d_gnt", 32'(bus.d_gnt), 1);
    chk("t1_mem_en", 32'(bus.mem_en), 1);
    chk("t1_mem_we", 32'(bus.mem_we), 1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
    chk("t1_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    chk("t1_busy2", 32'(busy), 0);
    chk("t1_no_rvalid", 32'(bus.d_rvalid), 0);
    data_read(16'h0010, rd, ok);
    chk("t1_readback_done", 32'(ok), 1);
    chk("t1_readback", 32'(rd), 32'hBEEF);

    // fetch with MEM_LAT=1
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    go_neg(1);
    chk("t2_if_gnt", 32'(bus.if_gnt), 1);
    chk("t2_busy1", 32'(busy), 1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("t2_busy2", 32'(busy), 1);
    chk("t2_rvalid2", 32'(bus.if_rvalid), 0);
    go_neg(1);
    chk("t2_rvalid3", 32'(bus.if_rvalid), 1);
    chk("t2_rdata3", 32'(bus.if_rdata), 32'h8C40);
    chk("t2_busy3", 32'(busy), 1);
    go_neg(1);
    chk("t2_busy4", 32'(busy), 0);
    chk("t2_rvalid4", 32'(bus.if_rvalid), 0);

    // anti-starvation: both held, data reads back to back
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0008;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0012;
    gq.delete();
    drop_if = 0;
    for (int k = 0; k < 200 && gq.size() < 6; k++) begin
      @(negedge clk);
      if (bus.if_gnt) begin
        gq.push_back(0);
        drop_if = 1;
        chk("t3_starve_clr", 32'(dut.u_pick.starve_cnt), 0);
      end
      if (bus.d_gnt) begin
        gq.push_back(1);
        if (gq.size() == 4) chk("t3_starve_max", 32'(dut.u_pick.starve_cnt), 4);
      end
      @(posedge clk); #1;
      if (drop_if) bus.if_req = 1'b0;
      if (gq.size() >= 6) bus.d_req = 1'b0;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("t3_grant_count", 32'(gq.size()), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk($sformatf("t3_order%0d", i), 32'(gq[i]), 32'(exp_order[i]));

    // reset during WAIT drops the read
    repeat (6) @(posedge clk);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_owner", 32'(owner), 0);
    chk("t5_mem_en", 32'(bus.mem_en), 0);
    chk("t5_d_rdata", 32'(bus.d_rdata), 0);
    chk("t5_if_rdata", 32'(bus.if_rdata), 0);
    chk("t5_mem_addr", 32'(bus.mem_addr), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen_v = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.d_rvalid) seen_v = 1;
    end
    chk("t5_no_rvalid", 32'(seen_v), 0);
    data_read(16'h0030, rd, ok);
    chk("t5_next_done", 32'(ok), 1);
    chk("t5_next_rdata", 32'(rd), 32'h30CF);

    // fetch request withdrawn right after sampling still completes
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0006;
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    seen_g = 0; seen_v = 0; rd = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.if_gnt) seen_g = 1;
      if (bus.if_rvalid) begin
        seen_v = 1;
        rd = bus.if_rdata;
      end
    end
    chk("t6_gnt", 32'(seen_g), 1);
    chk("t6_rvalid", 32'(seen_v), 1);
    chk("t6_rdata", 32'(rd), 32'h06F9);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
